// File: rtl/pixcache_flush_if.sv
// RAM-side request bus of the pixel-cache write-back engine.
// The flush engine is the master; the RAM arbiter is the slave.
interface pixcache_flush_if;
  logic        ram_req;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_ack;
  logic [7:0]  ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/pixcache_flush.sv
// Pixel-cache flush engine: turns one cached tile row (8 pixels) into SNES
// bitplane bytes and writes them to game-pak RAM. Partially drawn rows get a
// read-modify-write per plane so undrawn pixels keep their RAM contents.
// All state changes on the falling edge of clk, like the pixel cache itself.
module pixcache_flush (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [1:0]             bpp_mode,
  input  logic [16:0]            row_addr,
  input  logic [63:0]            pix_col,
  input  logic [7:0]             pix_valid,
  output logic                   busy,
  output logic                   done,
  pixcache_flush_if.master       ram
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_p;
  logic [2:0]  w_p_next;
  logic [2:0]  r_last_p;
  logic [16:0] r_row_addr;
  logic [63:0] r_col;
  logic [7:0]  r_valid;
  logic [7:0]  r_merge;
  logic        w_capture;
  logic        w_merge_load;
  logic        w_full;
  logic        w_req;
  logic [7:0]  w_pb;
  logic [16:0] w_addr;

  assign w_full = (r_valid == 8'hFF);

  // Gather bit p of every captured pixel into plane byte p; pixel 0 is the MSB.
  always_comb begin
    w_pb = '0;
    for (int i = 0; i < 8; i++) begin
      w_pb[7-i] = r_col[{3'(i), r_p}];
    end
  end

  // Plane pairs are interleaved: planes 2k and 2k+1 sit at +16k and +16k+1.
  assign w_addr = r_row_addr + {11'd0, r_p[2:1], 4'd0} + {16'd0, r_p[0]};

  // State register.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state, plane-counter and capture/merge strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    w_p_next     = r_p;
    w_capture    = 1'b0;
    w_merge_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_capture = 1'b1;
          w_p_next  = '0;
          if (pix_valid == 8'h00)      w_state_next = S_DONE;
          else if (pix_valid == 8'hFF) w_state_next = S_WRITE;
          else                         w_state_next = S_READ;
        end
      end
      S_READ: begin
        if (ram.ram_ack) begin
          w_merge_load = 1'b1;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ram.ram_ack) begin
          if (r_p == r_last_p) begin
            w_state_next = S_DONE;
          end else begin
            w_p_next     = r_p + 3'd1;
            w_state_next = w_full ? S_WRITE : S_READ;
          end
        end
      end
      S_DONE: begin
        w_p_next     = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Plane counter, captured row and read-modify-write merge byte.
  always_ff @(negedge clk) begin
    // NOTE: the captured row registers are reset too, so the decoded address
    // and write data come out of reset as zero rather than stale values.
    if (!reset_n) begin
      r_p        <= '0;
      r_last_p   <= '0;
      r_row_addr <= '0;
      r_col      <= '0;
      r_valid    <= '0;
      r_merge    <= '0;
    end else begin
      r_p <= w_p_next;
      if (w_capture) begin
        r_row_addr <= row_addr;
        r_col      <= pix_col;
        r_valid    <= pix_valid;
        unique case (bpp_mode)
          2'd0:    r_last_p <= 3'd1;
          2'd3:    r_last_p <= 3'd7;
          default: r_last_p <= 3'd3;
        endcase
      end
      if (w_merge_load) begin
        r_merge <= (ram.ram_rdata & ~r_valid) | (w_pb & r_valid);
      end
    end
  end

  // Outputs are decoded from registered state only.
  assign w_req         = (r_state == S_READ) || (r_state == S_WRITE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign ram.ram_req   = w_req;
  assign ram.ram_we    = (r_state == S_WRITE);
  assign ram.ram_addr  = w_req ? w_addr : '0;
  assign ram.ram_wdata = (r_state == S_WRITE) ? (w_full ? w_pb : r_merge) : '0;

endmodule

// File: tb/tb_pixcache_flush.sv
// Bench for pixcache_flush: a transaction-level model builds the expected
// access list when a flush is accepted and the outputs are compared against
// it every cycle; directed cases pin literal addresses, data and timing.
module tb_pixcache_flush;

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic        clk = 1'b1;
  logic        reset_n;
  logic        flush;
  logic [1:0]  bpp_mode;
  logic [16:0] row_addr;
  logic [63:0] pix_col;
  logic [7:0]  pix_valid;
  logic        busy;
  logic        done;

  pixcache_flush_if rif ();

  pixcache_flush u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .bpp_mode  (bpp_mode),
    .row_addr  (row_addr),
    .pix_col   (pix_col),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done),
    .ram       (rif)
  );

  always #5 clk = ~clk;

  // Game-pak RAM and its responder.
  logic [7:0] mem [0:131071];
  assign rif.ram_rdata = mem[rif.ram_addr];

  int          ack_mode = 0;   // 0 zero-wait, 1 random, 2 three wait cycles
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  int          busy_cyc, req_cyc, done_cnt, done_at, rd_cnt;
  logic [16:0] wl_addr [$];
  logic [7:0]  wl_data [$];

  // Model state: 0 idle, 1 accessing, 2 done.
  int   m_phase = 0;
  bit   m_rst_seen = 0;
  acc_t m_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] plane_byte(input logic [63:0] c, input int p);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = c[8*i+p];
    return b;
  endfunction

  function automatic logic [16:0] plane_addr(input logic [16:0] base, input int p);
    return 17'(base + 16*(p/2) + (p%2));
  endfunction

  // Reference model, advanced on the same falling edge the DUT uses.
  always @(negedge clk) begin
    m_rst_seen = 0;
    if (!reset_n) begin
      m_q.delete();
      m_phase    = 0;
      m_rst_seen = 1;
    end else begin
      case (m_phase)
        0: if (flush) begin
          int n;
          n = (bpp_mode == 2'd0) ? 2 : (bpp_mode == 2'd3) ? 8 : 4;
          if (pix_valid != 8'h00) begin
            for (int p = 0; p < n; p++) begin
              acc_t a;
              logic [7:0] pb;
              pb     = plane_byte(pix_col, p);
              a.addr = plane_addr(row_addr, p);
              if (pix_valid != 8'hFF) begin
                a.we   = 1'b0;
                a.data = 8'h00;
                m_q.push_back(a);
                a.data = (mem[a.addr] & ~pix_valid) | (pb & pix_valid);
              end else begin
                a.data = pb;
              end
              a.we = 1'b1;
              m_q.push_back(a);
            end
          end
          m_phase = (m_q.size() == 0) ? 2 : 1;
        end
        1: if (rif.ram_ack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare process: outputs are stable at the rising edge.
  always @(posedge clk) begin
    if (chk_en) begin
      check("busy", busy, 64'(m_phase != 0));
      check("done", done, 64'(m_phase == 2));
      check("ram_req", rif.ram_req, 64'(m_phase == 1));
      if (m_phase == 1 && m_q.size() > 0) begin
        check("ram_we", rif.ram_we, m_q[0].we);
        check("ram_addr", rif.ram_addr, m_q[0].addr);
        if (m_q[0].we) check("ram_wdata", rif.ram_wdata, m_q[0].data);
      end
      if (m_rst_seen) begin
        check("rst_we", rif.ram_we, 0);
        check("rst_addr", rif.ram_addr, 0);
        check("rst_wdata", rif.ram_wdata, 0);
      end
      if (busy) busy_cyc++;
      if (rif.ram_req) req_cyc++;
      if (done) begin
        done_cnt++;
        done_at = busy_cyc;
      end
    end
  end

  // RAM responder: decides ack away from the falling edge and commits the
  // access that the next falling edge will consume.
  always @(posedge clk) begin
    logic a;
    #2;
    case (ack_mode)
      0:       a = 1'b1;
      1:       a = ($urandom % 3) != 0;
      default: a = (wait_cnt == 3);
    endcase
    rif.ram_ack = a;
    if (rif.ram_req && reset_n) begin
      if (a) begin
        wait_cnt = 0;
        if (rif.ram_we) begin
          mem[rif.ram_addr] = rif.ram_wdata;
          wl_addr.push_back(rif.ram_addr);
          wl_data.push_back(rif.ram_wdata);
        end else begin
          rd_cnt++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_stats();
    busy_cyc = 0; req_cyc = 0; done_cnt = 0; done_at = 0; rd_cnt = 0;
    wl_addr.delete();
    wl_data.delete();
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", busy, 0);
  endtask

  // Present one flush for one cycle, then scramble the inputs so that any
  // use of live inputs after capture shows up.
  task automatic start_flush(input logic [1:0] b, input logic [16:0] a,
                             input logic [63:0] c, input logic [7:0] v);
    @(posedge clk); #1;
    flush = 1'b1; bpp_mode = b; row_addr = a; pix_col = c; pix_valid = v;
    @(posedge clk); #1;
    flush     = 1'b0;
    bpp_mode  = 2'($urandom);
    row_addr  = 17'($urandom);
    pix_col   = {$urandom, $urandom};
    pix_valid = 8'($urandom);
  endtask

  task automatic do_flush(input logic [1:0] b, input logic [16:0] a,
                          input logic [63:0] c, input logic [7:0] v);
    clear_stats();
    start_flush(b, a, c, v);
    wait_idle();
  endtask

  task automatic check_writes(input string n, input int cnt, input logic [16:0] base);
    check({n, "_wcount"}, wl_addr.size(), cnt);
    for (int p = 0; p < cnt && p < wl_addr.size(); p++) begin
      check({n, "_waddr"}, wl_addr[p], plane_addr(base, p));
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; bpp_mode = '0; row_addr = '0; pix_col = '0; pix_valid = '0;
    rif.ram_ack = 1'b0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    clear_stats();
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full 2bpp, zero-wait.
    ack_mode = 0;
    do_flush(2'd0, 17'h01000, 64'h0302010003020100, 8'hFF);
    check("f2_wcount", wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      check("f2_addr0", wl_addr[0], 17'h01000);
      check("f2_data0", wl_data[0], 8'h55);
      check("f2_addr1", wl_addr[1], 17'h01001);
      check("f2_data1", wl_data[1], 8'h33);
    end
    check("f2_reads", rd_cnt, 0);
    check("f2_done_at", done_at, 3);
    check("f2_busy", busy_cyc, 3);

    // Partial 4bpp over zeroed RAM.
    mem[17'h02000] = 8'h00; mem[17'h02001] = 8'h00;
    mem[17'h02010] = 8'h00; mem[17'h02011] = 8'h00;
    do_flush(2'd1, 17'h02000, {8{8'h0F}}, 8'h0F);
    check_writes("p4", 4, 17'h02000);
    for (int i = 0; i < wl_data.size(); i++) check("p4_data", wl_data[i], 8'h0F);
    check("p4_reads", rd_cnt, 4);
    check("p4_busy", busy_cyc, 9);

    // Empty row.
    do_flush(2'd3, 17'h00500, {$urandom, $urandom}, 8'h00);
    check("e_req", req_cyc, 0);
    check("e_done", done_cnt, 1);
    check("e_done_at", done_at, 1);
    check("e_busy", busy_cyc, 1);

    // Wait states, 8bpp full row.
    ack_mode = 2;
    do_flush(2'd3, 17'h03000, {$urandom, $urandom}, 8'hFF);
    check_writes("w8", 8, 17'h03000);
    check("w8_busy", busy_cyc, 33);
    check("w8_done", done_cnt, 1);

    // Reset during the second write of a 4bpp flush.
    ack_mode = 0;
    clear_stats();
    start_flush(2'd1, 17'h04000, {$urandom, $urandom}, 8'hFF);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", rif.ram_req, 0);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    check("rst_no_done", done_cnt, 0);
    do_flush(2'd1, 17'h04100, {$urandom, $urandom}, 8'hFF);
    check_writes("post_rst", 4, 17'h04100);
    check("post_rst_busy", busy_cyc, 5);

    // Flush pulsed while busy is ignored.
    ack_mode = 2;
    clear_stats();
    start_flush(2'd2, 17'h05000, {$urandom, $urandom}, 8'hFF);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1; row_addr = 17'h06000; pix_valid = 8'h00;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    check("bf_done", done_cnt, 1);
    check_writes("bf", 4, 17'h05000);

    // Address wrap.
    ack_mode = 0;
    do_flush(2'd1, 17'h1FFF1, {$urandom, $urandom}, 8'hFF);
    check("wrap_wcount", wl_addr.size(), 4);
    if (wl_addr.size() == 4) begin
      check("wrap_a0", wl_addr[0], 17'h1FFF1);
      check("wrap_a1", wl_addr[1], 17'h1FFF2);
      check("wrap_a2", wl_addr[2], 17'h00001);
      check("wrap_a3", wl_addr[3], 17'h00002);
    end

    // Randomised traffic: random acks, flush requests, inputs and resets.
    ack_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      int sel;
      @(posedge clk); #1;
      sel       = $urandom_range(0, 3);
      flush     = ($urandom % 4) == 0;
      bpp_mode  = 2'($urandom);
      row_addr  = 17'($urandom);
      pix_col   = {$urandom, $urandom};
      pix_valid = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      reset_n   = ($urandom % 150) != 0;
    end
    @(posedge clk); #1;
    flush = 1'b0; reset_n = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
